// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sequencer sharing one registered multiplier between two requesters
module mult_share_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int MULT_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [DATA_WIDTH-1:0]   req0_a,
  input  logic [DATA_WIDTH-1:0]   req0_b,
  output logic                    resp0_valid,
  input  logic                    resp0_ready,
  output logic [2*DATA_WIDTH-1:0] resp0_result,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [DATA_WIDTH-1:0]   req1_a,
  input  logic [DATA_WIDTH-1:0]   req1_b,
  output logic                    resp1_valid,
  input  logic                    resp1_ready,
  output logic [2*DATA_WIDTH-1:0] resp1_result,
  output logic                    busy,
  output logic                    mult_enable,
  output logic [DATA_WIDTH-1:0]   mult_a,
  output logic [DATA_WIDTH-1:0]   mult_b,
  input  logic [2*DATA_WIDTH-1:0] mult_result
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam logic [3:0] LAT = 4'(MULT_LATENCY);
  state_t state, state_n;
  logic [3:0] cnt;
  logic last_grant, owner, acc0, acc1, done, resp_ok;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [2*DATA_WIDTH-1:0] result;
  always_comb begin
    req0_ready = state == IDLE && (!req1_valid || last_grant);
    req1_ready = state == IDLE && (!req0_valid || !last_grant);
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    done = state == ISSUE && cnt == LAT;
    resp_ok = owner ? resp1_ready : resp0_ready;
    state_n = state == IDLE  ? ((acc0 || acc1) ? ISSUE : IDLE) :
              state == ISSUE ? (done ? RESP : ISSUE) :
                               (resp_ok ? IDLE : RESP);
    busy = state != IDLE;
    mult_enable = state == ISSUE;
    mult_a = op_a;
    mult_b = op_b;
    resp0_valid = state == RESP && !owner;
    resp1_valid = state == RESP && owner;
    resp0_result = resp0_valid ? result : '0;
    resp1_result = resp1_valid ? result : '0;
  end
  // acc0 and acc1 are mutually exclusive by construction of the ready terms
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b1;
      owner <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      if (acc0 || acc1) begin
        op_a <= acc0 ? req0_a : req1_a;
        op_b <= acc0 ? req0_b : req1_b;
        owner <= !acc0;
        last_grant <= !acc0;
        cnt <= '0;
      end else if (state == ISSUE) begin
        cnt <= cnt + 4'd1;
      end
      if (done) result <= mult_result;
    end
  end
endmodule
